// File: rtl/block_stream_pkg.sv
// Shared constants and types for the begin/end keyword character stream.
// The transmit and receive sides both import this package.
package block_stream_pkg;

  localparam int unsigned CHAR_W    = 8;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned CASE_W    = 5;
  localparam int unsigned GAP_W     = 3;
  localparam int unsigned LEN_BEGIN = 5;
  localparam int unsigned LEN_END   = 3;

  localparam logic [CHAR_W-1:0] ASCII_B     = 8'h62;
  localparam logic [CHAR_W-1:0] ASCII_E     = 8'h65;
  localparam logic [CHAR_W-1:0] ASCII_G     = 8'h67;
  localparam logic [CHAR_W-1:0] ASCII_I     = 8'h69;
  localparam logic [CHAR_W-1:0] ASCII_N     = 8'h6e;
  localparam logic [CHAR_W-1:0] ASCII_D     = 8'h64;
  localparam logic [CHAR_W-1:0] ASCII_SPACE = 8'h20;
  localparam logic [CHAR_W-1:0] CASE_OFFSET = 8'd32;

  typedef enum logic {
    OP_BEGIN = 1'b0,
    OP_END   = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WORD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  typedef struct packed {
    op_e               op;
    logic [CASE_W-1:0] case_mask;
  } cmd_t;

  // Index of the final letter of a word.
  function automatic logic [IDX_W-1:0] last_idx(input op_e op);
    return (op == OP_BEGIN) ? IDX_W'(LEN_BEGIN - 1) : IDX_W'(LEN_END - 1);
  endfunction

endpackage

// File: rtl/block_letter_rom.sv
// Maps (op, letter index, upper-case flag) to the ASCII byte of that letter.
// Out-of-range indices decode to 8'h00.
module block_letter_rom
  import block_stream_pkg::*;
(
  input  op_e               op_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic              upper_i,
  output logic [CHAR_W-1:0] letter_c
);

  logic [CHAR_W-1:0] lower;

  always_comb begin
    lower = 8'h00;
    if (op_i == OP_BEGIN) begin
      case (idx_i)
        3'd0:    lower = ASCII_B;
        3'd1:    lower = ASCII_E;
        3'd2:    lower = ASCII_G;
        3'd3:    lower = ASCII_I;
        3'd4:    lower = ASCII_N;
        default: lower = 8'h00;
      endcase
    end else begin
      case (idx_i)
        3'd0:    lower = ASCII_E;
        3'd1:    lower = ASCII_N;
        3'd2:    lower = ASCII_D;
        default: lower = 8'h00;
      endcase
    end
    letter_c = (upper_i && (lower != 8'h00)) ? (lower - CASE_OFFSET) : lower;
  end

endmodule

// File: rtl/block_stream_emitter.sv
// Serialises BEGIN/END commands into an ASCII char stream with trailing
// spaces and tracks the resulting nesting depth.
module block_stream_emitter
  import block_stream_pkg::*;
#(
  parameter int unsigned DEPTH_W = 32,
  parameter int unsigned GAP     = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_op,
  input  logic [CASE_W-1:0]  cmd_case,
  output logic [CHAR_W-1:0]  out_char,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DEPTH_W-1:0] depth,
  output logic               balanced,
  output logic               underflow,
  output logic               busy
);

  state_e              state_q, state_d;
  cmd_t                cmd_q, cmd_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic                underflow_q, underflow_d;
  logic                balanced_q, balanced_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic [CHAR_W-1:0]   out_char_q, out_char_d;
  logic                upper_next;
  logic [CHAR_W-1:0]   letter_next;

  // Letter lookup runs on next-state values so out_char can be registered.
  block_letter_rom u_rom (
    .op_i     (cmd_d.op),
    .idx_i    (idx_d),
    .upper_i  (upper_next),
    .letter_c (letter_next)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    depth_d     = depth_q;
    underflow_d = underflow_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_d.op        = op_e'(cmd_op);
          cmd_d.case_mask = cmd_case;
          idx_d           = '0;
          state_d         = ST_WORD;
        end
      end
      ST_WORD: begin
        if (out_ready) begin
          if (idx_q == last_idx(cmd_q.op)) begin
            if (cmd_q.op == OP_BEGIN) begin
              if (depth_q != {DEPTH_W{1'b1}}) depth_d = depth_q + DEPTH_W'(1);
            end else if (depth_q != '0) begin
              depth_d = depth_q - DEPTH_W'(1);
            end else begin
              underflow_d = 1'b1;
            end
            if (GAP == 0) begin
              state_d = ST_IDLE;
            end else begin
              gap_d   = GAP_W'(GAP);
              state_d = ST_GAP;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (out_ready) begin
          gap_d = gap_q - GAP_W'(1);
          if (gap_q == GAP_W'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    upper_next  = (idx_d < IDX_W'(CASE_W)) ? cmd_d.case_mask[idx_d] : 1'b0;
    out_valid_d = (state_d != ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    cmd_ready_d = (state_d == ST_IDLE);
    balanced_d  = (depth_d == '0) && !underflow_d;
    out_char_d  = '0;
    if (state_d == ST_WORD)     out_char_d = letter_next;
    else if (state_d == ST_GAP) out_char_d = ASCII_SPACE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      idx_q       <= '0;
      gap_q       <= '0;
      depth_q     <= '0;
      underflow_q <= 1'b0;
      balanced_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      out_char_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      depth_q     <= depth_d;
      underflow_q <= underflow_d;
      balanced_q  <= balanced_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
      out_char_q  <= out_char_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign out_char  = out_char_q;
  assign out_valid = out_valid_q;
  assign depth     = depth_q;
  assign balanced  = balanced_q;
  assign underflow = underflow_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_block_stream_emitter.sv
// Scoreboard bench: stimulus queues expected chars, monitors pop and compare
// on each handshake. Second instance covers GAP=3 and depth saturation.
module tb_block_stream_emitter;

  logic       clk = 1'b0;
  logic       reset;

  logic       cmd_valid, cmd_op, out_ready;
  logic [4:0] cmd_case;
  logic       cmd_ready, out_valid, balanced, underflow, busy;
  logic [7:0] out_char;
  logic [31:0] depth;

  logic       cmd_valid3, cmd_op3, out_ready3;
  logic [4:0] cmd_case3;
  logic       cmd_ready3, out_valid3, balanced3, underflow3, busy3;
  logic [7:0] out_char3;
  logic [1:0] depth3;

  logic [7:0] q0[$];
  logic [7:0] q3[$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  block_stream_emitter #(.DEPTH_W(32), .GAP(1)) u_dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_case(cmd_case), .out_char(out_char),
    .out_valid(out_valid), .out_ready(out_ready), .depth(depth),
    .balanced(balanced), .underflow(underflow), .busy(busy)
  );

  block_stream_emitter #(.DEPTH_W(2), .GAP(3)) u_dut3 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_op(cmd_op3), .cmd_case(cmd_case3), .out_char(out_char3),
    .out_valid(out_valid3), .out_ready(out_ready3), .depth(depth3),
    .balanced(balanced3), .underflow(underflow3), .busy(busy3)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: a handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q0.size() == 0) chk("dut1 unexpected char", 64'(out_char), 64'hffff);
      else chk("dut1 char", 64'(out_char), 64'(q0.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!reset && out_valid3 && out_ready3) begin
      if (q3.size() == 0) chk("dut3 unexpected char", 64'(out_char3), 64'hffff);
      else chk("dut3 char", 64'(out_char3), 64'(q3.pop_front()));
    end
  end

  task automatic issue(input int sel, input logic op, input logic [4:0] cs, input string exp);
    int n = 0;
    while (!((sel == 0) ? cmd_ready : cmd_ready3) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    chk("cmd_ready wait", 64'((sel == 0) ? cmd_ready : cmd_ready3), 64'd1);
    for (int i = 0; i < exp.len(); i++) begin
      if (sel == 0) q0.push_back(exp[i]);
      else q3.push_back(exp[i]);
    end
    if (sel == 0) begin cmd_valid = 1'b1; cmd_op = op; cmd_case = cs; end
    else begin cmd_valid3 = 1'b1; cmd_op3 = op; cmd_case3 = cs; end
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_valid3 = 1'b0;
    chk("first char latency valid", 64'((sel == 0) ? out_valid : out_valid3), 64'd1);
    chk("first char", 64'((sel == 0) ? out_char : out_char3), 64'(exp[0]));
  endtask

  task automatic drain(input int sel);
    int n = 0;
    while (n < 500 && !((sel == 0) ? (q0.size() == 0 && cmd_ready)
                                   : (q3.size() == 0 && cmd_ready3))) begin
      @(posedge clk); #1; n++;
    end
    chk("drain", 64'((sel == 0) ? (q0.size() == 0 && cmd_ready)
                                : (q3.size() == 0 && cmd_ready3)), 64'd1);
  endtask

  task automatic pulse_reset();
    q0.delete(); q3.delete();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_op = 1'b0; cmd_case = '0; out_ready = 1'b1;
    cmd_valid3 = 1'b0; cmd_op3 = 1'b0; cmd_case3 = '0; out_ready3 = 1'b1;
    #12;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_char", 64'(out_char), 64'd0);
    chk("reset depth", 64'(depth), 64'd0);
    chk("reset underflow", 64'(underflow), 64'd0);
    chk("reset balanced", 64'(balanced), 64'd1);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1/2: plain BEGIN then END
    issue(0, 1'b0, 5'b00000, "begin ");
    chk("busy during word", 64'(busy), 64'd1);
    drain(0);
    chk("t1 depth", 64'(depth), 64'd1);
    chk("t1 balanced", 64'(balanced), 64'd0);
    issue(0, 1'b1, 5'b00000, "end ");
    drain(0);
    chk("t2 depth", 64'(depth), 64'd0);
    chk("t2 balanced", 64'(balanced), 64'd1);
    chk("t2 underflow", 64'(underflow), 64'd0);

    // 3: underflow is sticky
    pulse_reset();
    issue(0, 1'b1, 5'b00000, "end ");
    drain(0);
    chk("t3 underflow", 64'(underflow), 64'd1);
    chk("t3 depth", 64'(depth), 64'd0);
    chk("t3 balanced", 64'(balanced), 64'd0);
    issue(0, 1'b0, 5'b00000, "begin ");
    issue(0, 1'b1, 5'b00000, "end ");
    drain(0);
    chk("t3 underflow sticky", 64'(underflow), 64'd1);
    chk("t3 balanced stays 0", 64'(balanced), 64'd0);
    chk("t3 depth after pair", 64'(depth), 64'd0);

    // 4: backpressure on 'g'; stray cmd_valid while busy is ignored
    pulse_reset();
    issue(0, 1'b0, 5'b00000, "begin ");
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("t4 stall char", 64'(out_char), 64'h67);
      chk("t4 stall valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    cmd_valid = 1'b0; cmd_op = 1'b0;
    drain(0);
    chk("t4 depth", 64'(depth), 64'd1);

    // 5: case masks, GAP=1 and GAP=3
    issue(0, 1'b0, 5'b10101, "BeGiN ");
    issue(0, 1'b1, 5'b11111, "END ");
    drain(0);
    chk("t5 depth", 64'(depth), 64'd1);
    issue(1, 1'b0, 5'b10101, "BeGiN   ");
    issue(1, 1'b1, 5'b00111, "END   ");
    drain(1);
    chk("t5 gap3 depth", 64'(depth3), 64'd0);
    chk("t5 gap3 balanced", 64'(balanced3), 64'd1);

    // depth saturates at all-ones on the 2-bit counter
    for (int k = 0; k < 4; k++) issue(1, 1'b0, 5'b00000, "begin   ");
    drain(1);
    chk("sat depth", 64'(depth3), 64'd3);
    chk("sat balanced", 64'(balanced3), 64'd0);
    issue(1, 1'b1, 5'b00000, "end   ");
    drain(1);
    chk("sat end depth", 64'(depth3), 64'd2);

    // 6: reset mid-word, after 'e' has been taken
    issue(0, 1'b0, 5'b00000, "begin ");
    @(posedge clk); #1;
    @(posedge clk); #1;
    q0.delete(); q3.delete();
    reset = 1'b1;
    #1;
    chk("t6 out_valid", 64'(out_valid), 64'd0);
    chk("t6 depth", 64'(depth), 64'd0);
    chk("t6 cmd_ready", 64'(cmd_ready), 64'd1);
    chk("t6 dut3 depth", 64'(depth3), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    issue(0, 1'b0, 5'b00000, "begin ");
    drain(0);
    chk("t6 restart depth", 64'(depth), 64'd1);

    chk("q0 empty", 64'(q0.size()), 64'd0);
    chk("q3 empty", 64'(q3.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
